key_expansion: RTL and testbench
================================

KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 Parameters: none; AES-128 only, 10 rounds, 11 round keys.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  global stall; when low, no state, counter, output or register changes.
REQ-005 start_i  input  1  request expansion of key_i; accepted only when ready_o=1 and en=1.
REQ-006 key_i  input  128  cipher key, sampled only on the accepting edge; byte 0 = key_i[127:120].
REQ-007 ready_o  output  1  high in IDLE and DONE; block can accept start_i.
REQ-008 valid_o  output  1  all 11 round keys on round_keys_o are complete and stable.
REQ-009 round_keys_o  output  1408  round key k (k=0..10) on bits [128k+127:128k]; feeds the round pipeline round_key_i inputs.

Function
REQ-010 FSM states IDLE, EXPAND, DONE; one-hot or binary encoding is acceptable.
REQ-011 IDLE + start_i + en: rk[0]<=key_i, cnt<=1, rcon<=8'h01, valid_o<=0, go to EXPAND.
REQ-012 EXPAND, each en cycle: rk[cnt]<=next(rk[cnt-1], rcon), cnt<=cnt+1, rcon<=xtime(rcon).
REQ-013 EXPAND with cnt==10 and en: write rk[10], valid_o<=1, go to DONE; cnt saturates and does not wrap.
REQ-014 Latency: valid_o rises on the 10th en-qualified edge after the accepting edge; en-low cycles extend latency one-for-one.
REQ-015 next(): w0..w3 = bits [127:96],[95:64],[63:32],[31:0]; t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-016 RotWord: {b1,b2,b3,b0}. SubWord: AES forward S-box per byte, combinational, internal to this block.
REQ-017 xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00); sequence 01,02,04,08,10,20,40,80,1B,36.
REQ-018 ready_o = (state==IDLE)||(state==DONE), combinational from state.
REQ-019 start_i in EXPAND is ignored, with no effect on keys, count or timing.
REQ-020 start_i in DONE with en: same action as REQ-011; valid_o falls on that edge, and old rk[1..10] remain visible until overwritten.
REQ-021 DONE holds rk[] and valid_o=1 indefinitely until the next accepted start_i or reset.
REQ-022 round_keys_o is driven directly from the rk[] registers, with no extra output register stage.
REQ-023 start_i with en=0 is not accepted in any state.

Reset
REQ-024 rst_n low, asynchronous: state=IDLE, cnt=0, rcon=8'h01, every rk[k]=128'd0, valid_o=0, ready_o=1.
REQ-025 Reset asserted during EXPAND aborts the expansion immediately; after release, the block waits in IDLE for a new start_i.
REQ-026 First accept is possible on the first en-qualified edge after rst_n deasserts.

Verification
REQ-027 Known-answer vector.
- Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, en=1.
- Response: rk1=a0fafe1788542cb123a339392a6c7605; rk10=d014f9a8c9ee2589e13f0cc8b6630ca6; valid_o high 10 edges after accept.
REQ-028 Zero key.
- Stimulus: key 0.
- Response: rk1=62636363626363636263636362636363; rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-029 Stall.
- Stimulus: known-answer key with en=0 for 3 cycles mid-EXPAND.
- Response: all outputs frozen while en=0; valid_o at accept+13 edges; keys identical to REQ-027.
REQ-030 Busy start.
- Stimulus: start_i with key 0 pulsed at cycle 4 of EXPAND for the known-answer key.
- Response: ignored; final keys match REQ-027; ready_o=0 throughout EXPAND.
REQ-031 Reset mid-run.
- Stimulus: rst_n low at cycle 5 of EXPAND.
- Response: same cycle, valid_o=0, ready_o=1, round_keys_o=0.
- Follow-up: zero-key run after release reproduces REQ-028.
REQ-032 Restart from DONE.
- Stimulus: after REQ-027, start_i with key 0.
- Response: valid_o falls on the accept edge, then rises 10 edges later with the REQ-028 keys.

Source files
------------

// File: rtl/key_expansion_if.sv
// AES-128 key expansion bus: global stall, start/key request and
// ready/valid status with the eleven concatenated round keys.
interface key_expansion_if;
  logic          en;
  logic          start_i;
  logic [127:0]  key_i;
  logic          ready_o;
  logic          valid_o;
  logic [1407:0] round_keys_o;

  modport master (
    output en,
    output start_i,
    output key_i,
    input  ready_o,
    input  valid_o,
    input  round_keys_o
  );

  modport slave (
    input  en,
    input  start_i,
    input  key_i,
    output ready_o,
    output valid_o,
    output round_keys_o
  );
endinterface

// File: rtl/key_expansion.sv
// AES-128 key schedule: one round key per enabled cycle into rk[0..10].
// Ports: clk, rst_n (async, active-low), bus (key_expansion_if.slave).
module key_expansion (
  input  logic           clk,
  input  logic           rst_n,
  key_expansion_if.slave bus
);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [7:0]   rcon;
  logic         valid;
  logic [127:0] rk [0:10];

  logic [3:0]   prev_idx;
  logic [127:0] prev;
  logic [31:0]  t;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [127:0] nxt;
  logic [7:0]   rcon_nxt;
  logic [1407:0] flat;

  // Byte b sits at bit offset 8*(255-b) == {~b, 3'b000}.
  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]),
            sb(w[15:8]),  sb(w[7:0])};
  endfunction

  always_comb begin
    prev_idx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    prev     = rk[prev_idx];
    t        = sub_word({prev[23:0], prev[31:24]})
             ^ {rcon, 24'h0};
    w0n      = prev[127:96] ^ t;
    w1n      = prev[95:64]  ^ w0n;
    w2n      = prev[63:32]  ^ w1n;
    w3n      = prev[31:0]   ^ w2n;
    nxt      = {w0n, w1n, w2n, w3n};
    rcon_nxt = {rcon[6:0], 1'b0}
             ^ (rcon[7] ? 8'h1B : 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rcon  <= 8'h01;
      valid <= 1'b0;
      for (int k = 0; k < 11; k++)
        rk[k] <= '0;
    end else if (bus.en) begin
      case (state)
        IDLE, DONE: begin
          if (bus.start_i) begin
            rk[0] <= bus.key_i;
            cnt   <= 4'd1;
            rcon  <= 8'h01;
            valid <= 1'b0;
            state <= EXPAND;
          end
        end
        EXPAND: begin
          rk[cnt] <= nxt;
          rcon    <= rcon_nxt;
          // cnt holds at 10 through DONE.
          if (cnt == 4'd10) begin
            valid <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    flat = '0;
    for (int k = 0; k < 11; k++)
      flat[128*k +: 128] = rk[k];
  end

  assign bus.round_keys_o = flat;
  assign bus.valid_o      = valid;
  assign bus.ready_o      = (state == IDLE)
                         || (state == DONE);

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: directed and random keys against a
// word-oriented FIPS-197 schedule model with a derived S-box.
module tb_key_expansion;

  logic clk;
  logic rst_n;
  key_expansion_if bus ();

  key_expansion dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbx [0:255];
  logic [127:0] exp_rk [0:10];

  localparam logic [127:0] KAT = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: GF(2^8) inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbx[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
             ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbx[tmp[31:24]], sbx[tmp[23:16]],
               sbx[tmp[15:8]], sbx[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 11; k++)
      exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_keys(input string tag);
    for (int k = 0; k < 11; k++)
      chk($sformatf("%s_rk%0d", tag, k),
          bus.round_keys_o[128*k +: 128], exp_rk[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One expansion: accept key, stall edges stall_at+1..stall_at+len,
  // pulse start with key 0 on edge busy_at+1, then wait for valid.
  task automatic run(input string tag, input logic [127:0] key,
                     input int stall_at, input int stall_len,
                     input int busy_at);
    int            edges;
    logic          stall;
    logic [1407:0] snap;
    bus.key_i   = key;
    bus.start_i = 1'b1;
    bus.en      = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.key_i   = {$urandom, $urandom, $urandom, $urandom};
    chk({tag, "_acc_valid"}, 128'(bus.valid_o), 128'd0);
    chk({tag, "_acc_ready"}, 128'(bus.ready_o), 128'd0);
    edges = 0;
    while (edges < 40) begin
      stall  = (edges >= stall_at) && (edges < stall_at + stall_len);
      bus.en = !stall;
      if (edges == busy_at) begin
        bus.start_i = 1'b1;
        bus.key_i   = '0;
      end
      snap = bus.round_keys_o;
      tick();
      edges++;
      bus.start_i = 1'b0;
      bus.en      = 1'b1;
      if (stall)
        chk({tag, "_freeze"},
            128'(snap == bus.round_keys_o && !bus.valid_o), 128'd1);
      if (bus.valid_o) break;
      chk({tag, "_busy_ready"}, 128'(bus.ready_o), 128'd0);
    end
    chk({tag, "_latency"}, 128'(edges), 128'(10 + stall_len));
    model(key);
    chk_keys(tag);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.en      = 1'b1;
    bus.start_i = 1'b0;
    bus.key_i   = '0;
    build_sbox();
    #12;
    chk("rst_valid", 128'(bus.valid_o), 128'd0);
    chk("rst_ready", 128'(bus.ready_o), 128'd1);
    chk("rst_keys", 128'(bus.round_keys_o == '0), 128'd1);
    rst_n = 1'b1;

    run("kat", KAT, 99, 0, 99);
    chk("kat_rk1", bus.round_keys_o[255:128],
        128'ha0fafe1788542cb123a339392a6c7605);
    chk("kat_rk10", bus.round_keys_o[1407:1280],
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int i = 0; i < 4; i++) begin
      bus.en = 1'($urandom);
      tick();
    end
    bus.en = 1'b1;
    chk("done_hold_valid", 128'(bus.valid_o), 128'd1);
    chk("done_hold_ready", 128'(bus.ready_o), 128'd1);
    chk_keys("done_hold");

    bus.en      = 1'b0;
    bus.start_i = 1'b1;
    bus.key_i   = '0;
    tick();
    bus.en      = 1'b1;
    bus.start_i = 1'b0;
    chk("done_en0_valid", 128'(bus.valid_o), 128'd1);
    chk_keys("done_en0");

    run("restart0", '0, 99, 0, 99);
    chk("zero_rk1", bus.round_keys_o[255:128],
        128'h62636363626363636263636362636363);
    chk("zero_rk10", bus.round_keys_o[1407:1280],
        128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    run("stall", KAT, 4, 3, 99);
    run("busy", KAT, 99, 0, 3);

    bus.key_i   = KAT;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 128'(bus.valid_o), 128'd0);
    chk("midrst_ready", 128'(bus.ready_o), 128'd1);
    chk("midrst_keys", 128'(bus.round_keys_o == '0), 128'd1);
    tick();
    tick();
    rst_n = 1'b1;
    bus.en      = 1'b0;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.en      = 1'b1;
    chk("idle_en0_ready", 128'(bus.ready_o), 128'd1);
    chk("idle_en0_keys", 128'(bus.round_keys_o == '0), 128'd1);
    run("after_rst", '0, 99, 0, 99);

    for (int r = 0; r < 8; r++)
      run($sformatf("rnd%0d", r),
          {$urandom, $urandom, $urandom, $urandom},
          int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 12)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
